onehot_req_arbiter8: RTL

//  Upstream stage of the 8-to-3 encoder. Captures rising edges on 8 request lines,

---
 rtl/onehot_arb_pkg.sv | 21 ++
 rtl/onehot_req_arbiter8_rr_pick.sv | 38 +++
 rtl/onehot_req_arbiter8.sv | 117 +++++++++++
 3 files changed

// File: rtl/onehot_arb_pkg.sv
// onehot_arb_pkg
// Shared definitions for the one-hot request arbiter that feeds the 8-to-3 encoder.
//   N      : number of request lines and the width of the one-hot grant word
//   IDX_W  : width of a request index and of the round-robin pointer
//   state_t: arbiter FSM states (IDLE waits for work, GRANT holds a grant until ack)
//   onehot : turns an index into a one-hot word of width N
package onehot_arb_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
        return {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/onehot_req_arbiter8_rr_pick.sv
// rr_pick
// Combinational round-robin selector.
//   pending in  N      : candidate requests
//   ptr     in  IDX_W  : index that has the highest priority this round
//   sel     out N      : one-hot winner, zero when nothing is pending
//   idx     out IDX_W  : index of the winner (don't care when sel is zero)
module rr_pick
    import onehot_arb_pkg::*;
(
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     sel,
    output logic [IDX_W-1:0] idx
);

    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic             found;

    // Rotate so ptr lands on bit 0, take the lowest set bit, then rotate the
    // offset back. N is a power of two, so the IDX_W-bit add wraps modulo N.
    always_comb begin
        dbl   = {pending, pending} >> ptr;
        rot   = dbl[N-1:0];
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                off   = IDX_W'(i);
                found = 1'b1;
            end
        end
        idx = off + ptr;
        sel = found ? onehot(idx) : '0;
    end

endmodule

// File: rtl/onehot_req_arbiter8.sv
// onehot_req_arbiter8
// Captures rising edges on the request lines, keeps them pending, and hands them
// one at a time, round-robin, to the encoder as a one-hot word with valid/ack.
//   clk     in   1 : clock
//   rst_n   in   1 : asynchronous active-low reset; drops any grant in flight
//   req     in   N : request lines, a 0->1 transition raises a request
//   en      in   1 : allows new grants (no effect on a grant already shown)
//   ack     in   1 : consumer took the current grant
//   Dout    out  N : one-hot grant, zero whenever valid is low
//   valid   out  1 : Dout holds a live grant
//   pending out  N : captured requests not yet granted
// Build option: define SYNC_REQ_EN to pass req through a 2-flop synchronizer
// before edge detection (adds 2 cycles of capture latency, allows async req).
module onehot_req_arbiter8
    import onehot_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    input  logic         ack,
    output logic [N-1:0] Dout,
    output logic         valid,
    output logic [N-1:0] pending
);

    logic [N-1:0]     req_s;
    logic [N-1:0]     req_q;
    logic [N-1:0]     rise;
    logic [N-1:0]     sel;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] gidx;
    logic [IDX_W-1:0] ptr;
    state_t           state;

`ifdef SYNC_REQ_EN
    logic [N-1:0] sync1;
    logic [N-1:0] sync2;

    // Two-flop synchronizer for requests coming from another clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= req;
            sync2 <= sync1;
        end
    end

    assign req_s = sync2;
`else
    assign req_s = req;
`endif

    // Previous request level, used to turn levels into one-cycle rise pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else begin
            req_q <= req_s;
        end
    end

    assign rise = req_s & ~req_q;

    rr_pick u_pick (
        .pending (pending),
        .ptr     (ptr),
        .sel     (sel),
        .idx     (pick_idx)
    );

    // Grant FSM. A new rise is OR-ed in after the ack clear, so an edge that
    // arrives together with the ack of the same bit keeps that bit pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            Dout    <= '0;
            valid   <= 1'b0;
            ptr     <= '0;
            gidx    <= '0;
            pending <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pending <= pending | rise;
                    if (en && (|pending)) begin
                        Dout  <= sel;
                        valid <= 1'b1;
                        gidx  <= pick_idx;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        pending <= (pending & ~Dout) | rise;
                        Dout    <= '0;
                        valid   <= 1'b0;
                        ptr     <= IDX_W'(gidx + 1'b1);
                        state   <= IDLE;
                    end else begin
                        pending <= pending | rise;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The encoder downstream relies on a clean one-hot (or zero) input.
    onehot_dout_a: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(Dout) && (valid == (Dout != '0)));

endmodule
